// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c master arbiter.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_COMPLETE
   } arb_state_t;

   localparam int unsigned ADDR_W          = 7;
   localparam int unsigned DATA_W          = 16;
   localparam int unsigned WD_W            = 16;
   localparam int unsigned TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority: first set request at or after ptr, with wrap.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            valid,
   output logic [PW-1:0]   idx
);

   int unsigned cand;

   // Walk offsets from farthest to nearest so the request closest to ptr wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int unsigned k = NREQ; k > 0; k--) begin
         cand = (32'(ptr) + k - 1) % NREQ;
         if (req[cand[PW-1:0]]) begin
            valid = 1'b1;
            idx   = cand[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin sharing of one i2c master between NREQ clients.
// Optional watchdog built in with `define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
   import i2c_pkg::*;
#(
   parameter int unsigned NREQ           = 4,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [ADDR_W*NREQ-1:0]   req_addr,
   input  logic [DATA_W*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]          req_rw,
   input  logic [NREQ-1:0]          req_two_bytes,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic [NREQ-1:0]          err,
   output logic [DATA_W-1:0]        rdata,
   output logic                     i2c_start,
   output logic [ADDR_W-1:0]        i2c_addr,
   output logic [DATA_W-1:0]        i2c_data,
   output logic                     i2c_rw,
   output logic                     i2c_two_bytes,
   input  logic                     i2c_ready,
   input  logic [DATA_W-1:0]        i2c_read_data
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t      state_q, state_d;
   logic [PW-1:0]   ptr_q;
   logic [PW-1:0]   idx_q;
   logic [PW-1:0]   ptr_next;
   logic            pick_valid;
   logic [PW-1:0]   pick_idx;
   logic [NREQ-1:0] pick_onehot;
   logic [NREQ-1:0] idx_onehot;
   logic            wd_hit;
   logic            timeout;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign pick_onehot = NREQ'(1) << pick_idx;
   assign idx_onehot  = NREQ'(1) << idx_q;
   assign ptr_next    = PW'((32'(idx_q) + 32'd1) % NREQ);

`ifdef I2C_ARB_TIMEOUT_EN
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_q;

   // Watchdog: cleared on launch, counts every cycle spent waiting on the master.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q <= '0;
      end else if (state_q == ST_LAUNCH) begin
         wd_q <= '0;
      end else if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_DONE) begin
         wd_q <= wd_q + WD_W'(1);
      end
   end

   assign wd_hit = (wd_q == WD_LAST);
`else
   // The limit only matters when the watchdog is built in.
   logic timeout_cfg_unused;
   assign timeout_cfg_unused = ^TIMEOUT_CYCLES;
   assign wd_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; a ready edge that arrives with the watchdog hit still wins.
   always_comb begin
      state_d = state_q;
      timeout = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i2c_ready && pick_valid) state_d = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!i2c_ready) begin
               state_d = ST_WAIT_DONE;
            end else if (wd_hit) begin
               state_d = ST_IDLE;
               timeout = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (i2c_ready) begin
               state_d = ST_COMPLETE;
            end else if (wd_hit) begin
               state_d = ST_IDLE;
               timeout = 1'b1;
            end
         end
         ST_COMPLETE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered outputs: launch registers, strobes, read data and pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q         <= '0;
         idx_q         <= '0;
         gnt           <= '0;
         done          <= '0;
         err           <= '0;
         rdata         <= '0;
         i2c_start     <= 1'b0;
         i2c_addr      <= '0;
         i2c_data      <= '0;
         i2c_rw        <= 1'b0;
         i2c_two_bytes <= 1'b0;
      end else begin
         i2c_start <= 1'b0;
         done      <= '0;
         err       <= '0;
         case (state_q)
            ST_IDLE: begin
               if (i2c_ready && pick_valid) begin
                  idx_q         <= pick_idx;
                  gnt           <= pick_onehot;
                  i2c_addr      <= req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
                  i2c_data      <= req_data[32'(pick_idx)*DATA_W +: DATA_W];
                  i2c_rw        <= req_rw[pick_idx];
                  i2c_two_bytes <= req_two_bytes[pick_idx];
               end
            end
            ST_LAUNCH: begin
               i2c_start <= 1'b1;
            end
            ST_WAIT_DONE: begin
               if (i2c_ready) rdata <= i2c_read_data;
            end
            ST_COMPLETE: begin
               done  <= idx_onehot;
               gnt   <= '0;
               ptr_q <= ptr_next;
            end
            default: begin
            end
         endcase
         if (timeout) begin
            err   <= idx_onehot;
            gnt   <= '0;
            ptr_q <= ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed and randomized checks of i2c_arbiter against a transaction-level model.
module tb_i2c_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned TMO  = 100;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req, req_rw, req_two_bytes;
   logic [7*NREQ-1:0]    req_addr;
   logic [16*NREQ-1:0]   req_data;
   logic [NREQ-1:0]      gnt, done, err;
   logic [15:0]          rdata, i2c_data, i2c_read_data;
   logic [6:0]           i2c_addr;
   logic                 i2c_start, i2c_rw, i2c_two_bytes, i2c_ready;

   int checks = 0;
   int errors = 0;
   int unsigned start_cnt = 0;
   int unsigned ptr_m = 0;
   logic [15:0] rdata_m = '0;

   logic [6:0]  c_addr [NREQ];
   logic [15:0] c_data [NREQ];
   logic        c_rw   [NREQ];
   logic        c_tb   [NREQ];

   always #5 clk = ~clk;

   always @(negedge clk) if (i2c_start === 1'b1) start_cnt++;

   i2c_arbiter #(
      .NREQ           (NREQ),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_rw        (req_rw),
      .req_two_bytes (req_two_bytes),
      .gnt           (gnt),
      .done          (done),
      .err           (err),
      .rdata         (rdata),
      .i2c_start     (i2c_start),
      .i2c_addr      (i2c_addr),
      .i2c_data      (i2c_data),
      .i2c_rw        (i2c_rw),
      .i2c_two_bytes (i2c_two_bytes),
      .i2c_ready     (i2c_ready),
      .i2c_read_data (i2c_read_data)
   );

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench did not finish");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bus();
      for (int i = 0; i < int'(NREQ); i++) begin
         req_addr[7*i +: 7]  = c_addr[i];
         req_data[16*i +: 16] = c_data[i];
         req_rw[i]           = c_rw[i];
         req_two_bytes[i]    = c_tb[i];
      end
   endtask

   task automatic randomize_clients();
      for (int i = 0; i < int'(NREQ); i++) begin
         c_addr[i] = 7'($urandom);
         c_data[i] = 16'($urandom);
         c_rw[i]   = 1'($urandom);
         c_tb[i]   = 1'($urandom);
      end
      load_bus();
   endtask

   // Rotate the request vector so ptr sits at bit 0, isolate the lowest set bit,
   // and map its offset back to a client number.
   function automatic int unsigned model_pick(input logic [NREQ-1:0] r, input int unsigned p);
      logic [2*NREQ-1:0] dbl, low;
      dbl = {r, r} >> p;
      low = dbl & (~dbl + 1'b1);
      return (p + $clog2(low)) % NREQ;
   endfunction

   // One complete transaction with the bench acting as the i2c master.
   task automatic txn(input int want_w, input int unsigned dly, input int unsigned busy,
                      input logic [15:0] rd, input bit drop, input bit mutate);
      int unsigned w, lat, s0;
      logic [6:0]  ea;
      logic [15:0] ed;
      logic        erw, etb;
      w   = (want_w >= 0) ? int'(want_w) : model_pick(req, ptr_m);
      ea  = c_addr[w];
      ed  = c_data[w];
      erw = c_rw[w];
      etb = c_tb[w];
      s0  = start_cnt;
      lat = 0;
      do begin
         step();
         lat++;
         if (lat == 1) check("done_one_cycle", done, 0);
      end while (gnt == '0 && lat < 20);
      check("grant_latency", lat, 1);
      check("gnt", gnt, 32'(1) << w);
      check("addr", i2c_addr, ea);
      check("data", i2c_data, ed);
      check("rw", i2c_rw, erw);
      check("two_bytes", i2c_two_bytes, etb);
      check("start_after_gnt", i2c_start, 0);
      step();
      check("start_pulse", i2c_start, 1);
      for (int unsigned k = 0; k < dly; k++) begin
         step();
         if (k == 0) check("start_one_cycle", i2c_start, 0);
      end
      i2c_ready = 1'b0;
      for (int unsigned k = 0; k < busy; k++) begin
         step();
         if (mutate && k == 0) begin
            req[w]    = 1'b0;
            c_addr[w] = 7'h22;
            c_data[w] = ~c_data[w];
            load_bus();
         end
      end
      check("hold_addr", i2c_addr, ea);
      check("hold_data", i2c_data, ed);
      check("hold_rw", {i2c_rw, i2c_two_bytes}, {erw, etb});
      check("hold_gnt", gnt, 32'(1) << w);
      i2c_read_data = rd;
      i2c_ready     = 1'b1;
      step();
      check("done_not_early", done, 0);
      step();
      check("done", done, 32'(1) << w);
      check("gnt_cleared", gnt, 0);
      check("rdata", rdata, rd);
      check("err_quiet", err, 0);
      check("start_count", start_cnt - s0, 1);
      rdata_m = rd;
      ptr_m   = (w + 1) % NREQ;
      if (drop) req[w] = 1'b0;
   endtask

   initial begin
      int unsigned w;
      rst           = 1'b1;
      req           = '0;
      i2c_ready     = 1'b1;
      i2c_read_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         c_addr[i] = '0;
         c_data[i] = '0;
         c_rw[i]   = 1'b0;
         c_tb[i]   = 1'b0;
      end
      load_bus();
      step();
      step();
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      check("rst_start", i2c_start, 0);
      check("rst_fields", {i2c_addr, i2c_data, i2c_rw, i2c_two_bytes}, 0);
      rst = 1'b0;
      step();

      // Single write from client 1.
      c_addr[1] = 7'h50; c_data[1] = 16'haa55; c_rw[1] = 1'b0; c_tb[1] = 1'b0;
      load_bus();
      req = 4'b0010;
      txn(1, 3, 40, 16'h1234, 1'b1, 1'b0);

      // Two-byte read from client 2.
      c_addr[2] = 7'h3c; c_data[2] = 16'h0000; c_rw[2] = 1'b1; c_tb[2] = 1'b1;
      load_bus();
      req = 4'b0100;
      txn(2, 2, 12, 16'ha7b8, 1'b1, 1'b0);

      // Round robin from a fresh pointer with all requests held.
      rst = 1'b1;
      #1;
      check("rst2_rdata", rdata, 0);
      step();
      rst   = 1'b0;
      ptr_m = 0;
      randomize_clients();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         txn(k % 4, $urandom_range(1, 4), $urandom_range(1, 20), 16'($urandom), 1'b0, 1'b0);
      end
      req = '0;

      // Client 0 drops its request and changes its address mid-transaction.
      c_addr[0] = 7'h50; c_data[0] = 16'h0f0f; c_rw[0] = 1'b0; c_tb[0] = 1'b1;
      load_bus();
      req = 4'b0001;
      txn(0, 2, 10, 16'h5a5a, 1'b1, 1'b1);

      // Bus held by another master: nothing may be granted or launched.
      c_addr[0] = 7'h11; c_data[0] = 16'hbeef;
      load_bus();
      i2c_ready = 1'b0;
      req       = 4'b0001;
      step();
      check("busy_done_one_cycle", done, 0);
      for (int k = 0; k < 50; k++) begin
         step();
         check("busy_no_grant", {gnt, i2c_start}, 0);
      end
      i2c_ready = 1'b1;
      txn(0, 1, 5, 16'h0bad, 1'b1, 1'b0);

      // Reset in the middle of a transaction.
      c_addr[3] = 7'h2a; c_data[3] = 16'hc001;
      load_bus();
      req = 4'b1000;
      for (int k = 0; k < 20 && gnt == '0; k++) step();
      check("mid_gnt", gnt, 4'b1000);
      step();
      step();
      i2c_ready = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      check("mid_rst_outputs", {gnt, done, i2c_start, i2c_addr}, 0);
      step();
      rst   = 1'b0;
      ptr_m = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("mid_rst_wait_ready", {gnt, i2c_start}, 0);
      end
      i2c_ready = 1'b1;
      txn(-1, 2, 6, 16'h7e57, 1'b1, 1'b0);

      // Randomized traffic against the round-robin model.
      for (int t = 0; t < 12; t++) begin
         randomize_clients();
         req = req | 4'($urandom_range(1, 15));
         txn(-1, $urandom_range(1, 4), $urandom_range(1, 30), 16'($urandom), 1'b1, (t % 3) == 0);
      end
      req = '0;
      step();
      check("final_done_one_cycle", done, 0);

`ifdef I2C_ARB_TIMEOUT_EN
      // Master never reports completion: watchdog must fire instead of done.
      for (int k = 0; k < 6; k++) step();
      randomize_clients();
      req = 4'b0110;
      w   = model_pick(req, ptr_m);
      for (int k = 0; k < 20 && gnt == '0; k++) step();
      check("tmo_gnt", gnt, 32'(1) << w);
      step();
      check("tmo_start", i2c_start, 1);
      i2c_ready = 1'b0;
      for (int unsigned k = 1; k <= TMO; k++) begin
         step();
         if (k < TMO) check("tmo_quiet", {err, done}, 0);
      end
      check("tmo_err", err, 32'(1) << w);
      check("tmo_no_done", done, 0);
      check("tmo_gnt_cleared", gnt, 0);
      check("tmo_rdata_kept", rdata, rdata_m);
      ptr_m     = (w + 1) % NREQ;
      req       = 4'b1111;
      i2c_ready = 1'b1;
      txn(-1, 1, 4, 16'h4242, 1'b1, 1'b0);
      req = '0;
      step();
`else
      w = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         check("err_tied_low", err, w);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter and sequencer that shares the single `i2c` master between `NREQ` client blocks. It selects one pending requester and drives that requester's address, data, direction and length onto the master. It pulses the master's `start` and tracks `ready` through the transaction. It then returns the read data and a one-cycle completion strobe to the winning client. It sits between the sensor/config clients and the `i2c` master; the master's `scl`/`sda` pins are untouched.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in `clk` cycles. Used only with `I2C_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock. This block has one clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: per-client request. The client holds it high until its `done` bit is asserted.
- `req_addr` in 7*NREQ: packed 7-bit slave addresses. Client i occupies bits [7i+6:7i].
- `req_data` in 16*NREQ: packed write data.
- `req_rw` in NREQ: direction per client, 1 = read.
- `req_two_bytes` in NREQ: length per client, 1 = two bytes.
- `gnt` out NREQ: one-hot; the client currently owning the master.
- `done` out NREQ: one-hot, one-cycle completion strobe.
- `err` out NREQ: one-hot, one-cycle timeout strobe. Tied to 0 when the macro is absent.
- `rdata` out 16: read data of the last completed transaction.
- `i2c_start` out 1: drives master `start`.
- `i2c_addr` out 7: drives master `addr`.
- `i2c_data` out 16: drives master `data`.
- `i2c_rw` out 1: drives master `rw`.
- `i2c_two_bytes` out 1: drives master `two_bytes`.
- `i2c_ready` in 1: master `ready`. High means the master is idle and the bus is free.
- `i2c_read_data` in 16: master `read_data`.

## Operation
- States:
  - IDLE
  - LAUNCH
  - WAIT_BUSY
  - WAIT_DONE
  - COMPLETE
- IDLE transition:
  - Condition: `|req` and `i2c_ready`=1.
  - Winner: the first set `req` bit at or after the pointer `ptr`, searching upward with wrap.
  - Latch the winner's index, addr, data, rw and two_bytes into the launch registers.
  - Set `gnt`.
  - Go to LAUNCH.
- IDLE hold: if `i2c_ready`=0 (another bus master active), stay in IDLE and issue no grant.
- LAUNCH: `i2c_start`=1 for this one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: when `i2c_ready`=0, go to WAIT_DONE.
- WAIT_DONE: when `i2c_ready`=1, capture `i2c_read_data` into `rdata` and go to COMPLETE.
- COMPLETE:
  - Pulse `done[idx]`.
  - Clear `gnt`.
  - Set `ptr` = idx+1 mod NREQ.
  - Go to IDLE.
- `rdata` is also captured on writes, where its value is don't-care. `rdata` holds its value until the next COMPLETE.
- Launch registers are frozen from grant to COMPLETE. Client input changes mid-transaction have no effect.
- If a client drops `req` mid-transaction, the transaction still completes and `done` still pulses.
- Only the `req` bits present in IDLE are arbitrated. A `req` arriving later waits for the next IDLE.

## Timing
- Reset values:
  - State: IDLE.
  - `ptr`: 0.
  - `gnt`, `done`, `err`: 0.
  - `rdata`: 0.
  - `i2c_start`: 0.
  - `i2c_addr`, `i2c_data`, `i2c_rw`, `i2c_two_bytes`: 0.
- Reset mid-transaction returns to IDLE immediately. The master is not aborted, so the next launch waits for `i2c_ready`.
- All outputs are registered.
- Sequence and latency:
  - Edge 0: `req` sampled in IDLE.
  - Edge 1: `gnt` and `i2c_*` fields valid.
  - Cycle after edge 1: `i2c_start` high for exactly one cycle.
  - `done` asserts 2 edges after `i2c_ready` rises in WAIT_DONE.
- Back-to-back: the minimum gap between two `i2c_start` pulses is the master busy time plus 4 cycles.
- The `i2c_*` fields stay stable from grant until COMPLETE.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - A 16-bit watchdog counts cycles spent in WAIT_BUSY plus WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES`: pulse `err[idx]` instead of `done`, leave `rdata` unchanged, advance `ptr`, and return to IDLE.
  - A missing `ready` drop also counts toward the timeout.
- `I2C_ARB_TIMEOUT_EN` undefined: no counter, `err`=0, and WAIT states wait indefinitely.

## Structure
- Package `i2c_pkg` holds:
  - The state enum.
  - Field widths: ADDR_W=7, DATA_W=16.
  - The default `TIMEOUT_CYCLES`.
- Sub-module `rr_pick`: combinational round-robin priority. Inputs `req` and `ptr`; outputs `valid` and `idx`.

## Test plan
- Single write:
  - Stimulus: NREQ=4; client 1 requests addr 7'h50, data 16'haa55, rw=0, two_bytes=0; model master drops `ready` 3 cycles after start and raises it 40 cycles later.
  - Response: `gnt`=4'b0010; `i2c_addr`=7'h50; `i2c_data`=16'haa55; one `i2c_start` pulse; `done`=4'b0010 for 1 cycle.
- Read:
  - Stimulus: client 2, rw=1, two_bytes=1; model returns 16'ha7b8.
  - Response: `rdata`=16'ha7b8 in the cycle `done[2]` asserts.
- Round-robin:
  - Stimulus: `req`=4'b1111 held.
  - Response: grant order 0,1,2,3,0. Each grant completes before the next `i2c_start`.
- Bus busy:
  - Stimulus: `i2c_ready`=0 held 50 cycles while `req`=4'b0001.
  - Response: no `gnt` and no `i2c_start` until `ready` rises; grant on the following edge.
- Client change mid-transaction:
  - Stimulus: client 0 drops `req` and changes `req_addr` to 7'h22 during WAIT_DONE.
  - Response: `i2c_addr` stays 7'h50; `done[0]` still pulses.
- Timeout (`I2C_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100):
  - Stimulus: `ready` never returns high.
  - Response: `err[idx]` pulses 100 cycles after entering WAIT_BUSY; no `done`; `ptr` advances.
